// File: rtl/line_serializer.sv
// Cache-line to bus-word serializer: captures one line and streams it out LSB word first
// under a valid/ready handshake. Define SER_PARITY_EN to add the word_par output.
module line_serializer #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WORD_W*LINE_WORDS-1:0] line_in,
  input  logic                         load,
  output logic                         load_ready,
  output logic [WORD_W-1:0]            word_out,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [IDX_W-1:0]             word_idx,
  output logic                         busy,
`ifdef SER_PARITY_EN
  output logic                         word_par,
`endif
  output logic                         done
);

  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   line_words [LINE_WORDS];

  // Word lanes are taken from the next-state line so word_out can be registered.
  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_lanes
      assign line_words[gi] = line_d[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    line_d  = line_q;
    word_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          line_d  = line_in;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (word_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_SEND) begin
      word_d = line_words[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      line_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      word_q  <= word_d;
    end
  end

`ifdef SER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^word_d;
    end
  end

  assign word_par = par_q;
`endif

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign word_valid = (state_q == ST_SEND);
  assign word_idx   = idx_q;
  assign word_out   = word_q;

endmodule

// File: tb/tb_line_serializer.sv
// Directed self-checking bench for line_serializer; covers streaming, stalls, ignored loads,
// reset abort, back-to-back loads and (with SER_PARITY_EN) word parity.
module tb_line_serializer;

  logic         clk;
  logic         rst;
  logic [255:0] line_in;
  logic         load;
  logic         load_ready;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic [2:0]   word_idx;
  logic         busy;
  logic         done;
`ifdef SER_PARITY_EN
  logic         word_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  line_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .load       (load),
    .load_ready (load_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_idx   (word_idx),
    .busy       (busy),
`ifdef SER_PARITY_EN
    .word_par   (word_par),
`endif
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_basic_line;
    for (int i = 0; i < 8; i++) line_in[i*32 +: 32] = 32'h11111111 * (i + 1);
  endtask

  task automatic drain_to_idle(input string name);
    int n;
    n = 0;
    load = 1'b0;
    word_ready = 1'b1;
    while (load_ready !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_drain: load_ready=%b required 1 within 30 cycles", name, load_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; word_ready = 1'b0; line_in = '1;
    step(); step();
    n_cmp++;
    if ({word_valid, word_out, word_idx, busy, done, load_ready} !== {1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b out=%h idx=%0d busy=%b done=%b lr=%b required 0/0/0/0/0/1",
               word_valid, word_out, word_idx, busy, done, load_ready);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic;
    logic [31:0] exp;
    set_basic_line();
    load = 1'b1; word_ready = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = 32'h11111111 * (i + 1);
      $display("basic beat idx=%0d word=%h valid=%b", word_idx, word_out, word_valid);
      n_cmp++;
      if ({word_valid, word_idx, word_out, load_ready} !== {1'b1, 3'(i), exp, 1'b0}) begin
        n_bad++;
        $display("FAIL basic_beat%0d: valid=%b idx=%0d out=%h lr=%b required 1/%0d/%h/0",
                 i, word_valid, word_idx, word_out, load_ready, i, exp);
      end
      step();
    end
    n_cmp++;
    if ({done, word_valid, word_out, busy, load_ready} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_done: done=%b valid=%b out=%h busy=%b lr=%b required 1/0/0/1/0",
               done, word_valid, word_out, busy, load_ready);
    end
    step();
    n_cmp++;
    if ({done, busy, load_ready, word_valid} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_idle: done=%b busy=%b lr=%b valid=%b required 0/0/1/0",
               done, busy, load_ready, word_valid);
    end
  endtask

  task automatic test_backpressure;
    int k, stall, done_cyc;
    logic [31:0] exp;
    set_basic_line();
    k = 0; stall = 0; done_cyc = -1;
    load = 1'b1; word_ready = 1'b1;
    step();
    load = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (word_valid === 1'b1) begin
        exp = 32'h11111111 * (k + 1);
        $display("stall cyc=%0d idx=%0d word=%h ready=%b", cyc, word_idx, word_out, word_ready);
        n_cmp++;
        if ({word_idx, word_out} !== {3'(k), exp}) begin
          n_bad++;
          $display("FAIL bp_beat_cyc%0d: idx=%0d out=%h required %0d/%h", cyc, word_idx, word_out, k, exp);
        end
        if (k == 2 && stall < 3) begin
          word_ready = 1'b0;
          stall++;
        end else begin
          word_ready = 1'b1;
          k++;
        end
      end
      step();
    end
    word_ready = 1'b1;
    n_cmp++;
    if (done_cyc != 12 || k != 8) begin
      n_bad++;
      $display("FAIL bp_done: done_cycle=%0d beats=%0d required 12/8", done_cyc, k);
    end
    drain_to_idle("bp");
  endtask

  task automatic test_load_while_busy;
    int k, seen_done;
    line_in = {8{32'hAAAAAAAA}};
    k = 0; seen_done = 0;
    load = 1'b1; word_ready = 1'b1;
    step();
    load = 1'b0;
    for (int cyc = 1; cyc <= 20 && seen_done == 0; cyc++) begin
      if (word_valid === 1'b1) begin
        n_cmp++;
        if ({word_idx, word_out} !== {3'(k), 32'hAAAAAAAA}) begin
          n_bad++;
          $display("FAIL lwb_beat%0d: idx=%0d out=%h required %0d/aaaaaaaa", k, word_idx, word_out, k);
        end
        line_in = {8{32'hBBBBBBBB}};
        load = (k == 4);
        k++;
        step();
      end else if (done === 1'b1) begin
        seen_done = 1;
        load = 1'b1;
        step();
        load = 1'b0;
      end else begin
        step();
      end
    end
    $display("load-while-busy beats=%0d", k);
    n_cmp++;
    if ({k == 8, load_ready, busy, word_valid} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL lwb_after_done: beats=%0d lr=%b busy=%b valid=%b required 8/1/0/0",
               k, load_ready, busy, word_valid);
    end
    step();
    n_cmp++;
    if ({word_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL lwb_no_b: valid=%b busy=%b required 0/0", word_valid, busy);
    end
  endtask

  task automatic test_reset_midop;
    int n, dones;
    set_basic_line();
    load = 1'b1; word_ready = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (word_idx !== 3'd5 && n < 20) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({word_valid, word_out, busy, load_ready, done, word_idx} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_state: valid=%b out=%h busy=%b lr=%b done=%b idx=%0d required 0/0/0/1/0/0",
               word_valid, word_out, busy, load_ready, done, word_idx);
    end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL rst_mid_nodone: done pulses=%0d required 0", dones);
    end
    load = 1'b1;
    step();
    load = 1'b0;
    $display("reload after reset idx=%0d word=%h", word_idx, word_out);
    n_cmp++;
    if ({word_valid, word_idx, word_out} !== {1'b1, 3'd0, 32'h11111111}) begin
      n_bad++;
      $display("FAIL rst_mid_reload: valid=%b idx=%0d out=%h required 1/0/11111111",
               word_valid, word_idx, word_out);
    end
    drain_to_idle("rst_mid");
  endtask

  task automatic test_back_to_back;
    int t [$];
    set_basic_line();
    load = 1'b1; word_ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (done === 1'b1) begin
        t.push_back(c);
        $display("back-to-back done at cycle %0d", c);
      end
      if (c == 11) begin
        n_cmp++;
        if ({word_valid, word_idx, word_out} !== {1'b1, 3'd0, 32'h11111111}) begin
          n_bad++;
          $display("FAIL b2b_second_line: valid=%b idx=%0d out=%h required 1/0/11111111",
                   word_valid, word_idx, word_out);
        end
      end
    end
    n_cmp++;
    if (t.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count: done pulses=%0d required 3", t.size());
    end else begin
      n_cmp++;
      if (t[1] - t[0] != 10 || t[2] - t[1] != 10 || t[0] != 9) begin
        n_bad++;
        $display("FAIL b2b_spacing: first=%0d gaps=%0d,%0d required 9/10,10", t[0], t[1] - t[0], t[2] - t[1]);
      end
    end
    drain_to_idle("b2b");
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity;
    logic [3:0] par_exp;
    par_exp = 4'b0001;
    line_in = '0;
    line_in[31:0]   = 32'h00000001;
    line_in[63:32]  = 32'h00000003;
    line_in[95:64]  = 32'hFFFFFFFF;
    line_in[127:96] = 32'h00000000;
    n_cmp++;
    if (word_par !== 1'b0) begin
      n_bad++;
      $display("FAIL par_idle: word_par=%b required 0", word_par);
    end
    load = 1'b1; word_ready = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      $display("parity word=%h par=%b", word_out, word_par);
      n_cmp++;
      if (word_par !== par_exp[i]) begin
        n_bad++;
        $display("FAIL par_word%0d: word_par=%b required %b", i, word_par, par_exp[i]);
      end
      step();
    end
    drain_to_idle("par");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_load_while_busy();
    test_reset_midop();
    test_back_to_back();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
